// File: rtl/gobang_axil_regs.sv
// rtl/gobang_axil_regs.sv - AXI4-Lite slave register bank with RW control words and RO status words
module gobang_axil_regs #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_NUM_REGS   = 8,
   parameter int C_NUM_RO     = 2,
   parameter int C_ADDR_WIDTH = 8
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic [C_ADDR_WIDTH-1:0]            AWADDR,
   input  logic [2:0]                         AWPROT,
   input  logic                               AWVALID,
   output logic                               AWREADY,
   input  logic [C_DATA_WIDTH-1:0]            WDATA,
   input  logic [C_DATA_WIDTH/8-1:0]          WSTRB,
   input  logic                               WVALID,
   output logic                               WREADY,
   output logic [1:0]                         BRESP,
   output logic                               BVALID,
   input  logic                               BREADY,
   input  logic [C_ADDR_WIDTH-1:0]            ARADDR,
   input  logic [2:0]                         ARPROT,
   input  logic                               ARVALID,
   output logic                               ARREADY,
   output logic [C_DATA_WIDTH-1:0]            RDATA,
   output logic [1:0]                         RRESP,
   output logic                               RVALID,
   input  logic                               RREADY,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] regs_o,
   input  logic [C_NUM_RO*C_DATA_WIDTH-1:0]   status_i,
   output logic [C_NUM_REGS-1:0]              wr_pulse_o
);
   localparam int NB     = C_DATA_WIDTH / 8;
   localparam int OFFW   = $clog2(NB);
   localparam int IDXW   = $clog2(C_NUM_REGS);
   localparam int NUM_RW = C_NUM_REGS - C_NUM_RO;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_ACCEPT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_RESP} rstate_t;

   wstate_t wstate, wstate_nxt;
   rstate_t rstate, rstate_nxt;

   // ready outputs stay low until the first clock edge after reset is released
   logic                    active;
   logic                    aw_done, w_done;
   logic [C_ADDR_WIDTH-1:0] aw_addr_q;
   logic [C_DATA_WIDTH-1:0] w_data_q;
   logic [NB-1:0]           w_strb_q;

   logic                    aw_hs, w_hs, ar_hs, commit;
   logic [C_ADDR_WIDTH-1:0] wr_addr;
   logic [C_DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]           wr_strb;
   logic [IDXW-1:0]         wr_idx, rd_idx;
   logic                    wr_oor, rd_oor, wr_ok;
   logic [C_NUM_REGS-1:0]   wr_sel, rw_mask;
   logic [C_DATA_WIDTH-1:0] view [C_NUM_REGS];

   // protection bits carry no meaning for this block
   logic unused_prot;
   assign unused_prot = ^{AWPROT, ARPROT};

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign ar_hs = ARVALID & ARREADY;

   // a beat captured in an earlier cycle wins over the live bus value
   assign wr_addr = aw_done ? aw_addr_q : AWADDR;
   assign wr_data = w_done ? w_data_q : WDATA;
   assign wr_strb = w_done ? w_strb_q : WSTRB;

   // the write commits on the edge where the second of the two beats lands
   assign commit = (wstate == W_ACCEPT) & (aw_done | aw_hs) & (w_done | w_hs);

   assign wr_idx = wr_addr[OFFW +: IDXW];
   assign wr_oor = (wr_addr >> (OFFW + IDXW)) != '0;
   assign wr_ok  = ~wr_oor & rw_mask[wr_idx];
   assign wr_sel = {{(C_NUM_REGS-1){1'b0}}, 1'b1} << wr_idx;

   assign rd_idx = ARADDR[OFFW +: IDXW];
   assign rd_oor = (ARADDR >> (OFFW + IDXW)) != '0;

   // register storage for writable words; status words pass through to the read view
   for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
      if (i < NUM_RW) begin : g_rw
         logic [C_DATA_WIDTH-1:0] q;
         // byte-lane update on a committed write that targets this word
         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
               q <= '0;
            end else if (commit && wr_ok && wr_sel[i]) begin
               for (int b = 0; b < NB; b++) begin
                  if (wr_strb[b]) q[b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
         assign view[i]    = q;
         assign rw_mask[i] = 1'b1;
         assign regs_o[i*C_DATA_WIDTH +: C_DATA_WIDTH] = q;
      end else begin : g_ro
         assign view[i]    = status_i[(i-NUM_RW)*C_DATA_WIDTH +: C_DATA_WIDTH];
         assign rw_mask[i] = 1'b0;
         assign regs_o[i*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
      end
   end

   // enable the ready outputs one edge after reset release
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) active <= 1'b0;
      else        active <= 1'b1;
   end

   // write FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) wstate <= W_ACCEPT;
      else        wstate <= wstate_nxt;
   end

   // write FSM next state
   always_comb begin
      wstate_nxt = wstate;
      case (wstate)
         W_ACCEPT: if (commit) wstate_nxt = W_RESP;
         W_RESP:   if (BREADY) wstate_nxt = W_ACCEPT;
         default:  wstate_nxt = W_ACCEPT;
      endcase
   end

   // write FSM outputs: each ready drops once its own beat is held
   always_comb begin
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      case (wstate)
         W_ACCEPT: begin
            AWREADY = active & ~aw_done;
            WREADY  = active & ~w_done;
         end
         W_RESP:   BVALID = 1'b1;
         default:  ;
      endcase
   end

   // hold whichever write beat arrives first until its partner shows up
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_done   <= 1'b1;
            aw_addr_q <= AWADDR;
         end
         if (w_hs) begin
            w_done   <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
         end
      end
   end

   // write response code and single-cycle update strobe, both set at commit
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         BRESP      <= RESP_OKAY;
         wr_pulse_o <= '0;
      end else begin
         wr_pulse_o <= (commit && wr_ok) ? wr_sel : '0;
         if (commit) BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // read FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) rstate <= R_IDLE;
      else        rstate <= rstate_nxt;
   end

   // read FSM next state
   always_comb begin
      rstate_nxt = rstate;
      case (rstate)
         R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
         R_RESP:  if (RREADY) rstate_nxt = R_IDLE;
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // read FSM outputs
   always_comb begin
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      case (rstate)
         R_IDLE:  ARREADY = active;
         R_RESP:  RVALID  = 1'b1;
         default: ;
      endcase
   end

   // read data snapshot at the address handshake; a same-edge write is not yet visible
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         RDATA <= '0;
         RRESP <= RESP_OKAY;
      end else if (ar_hs) begin
         RDATA <= rd_oor ? '0 : view[rd_idx];
         RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
   end

endmodule

// File: tb/tb_gobang_axil_regs.sv
// tb/tb_gobang_axil_regs.sv - self-checking bench for gobang_axil_regs
`timescale 1ns/1ps
module tb_gobang_axil_regs;
   localparam int W   = 32;
   localparam int N   = 8;
   localparam int NRO = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]     awaddr, araddr;
   logic [2:0]     awprot, arprot;
   logic           awvalid, wvalid, bready, arvalid, rready;
   logic           awready, wready, bvalid, arready, rvalid;
   logic [31:0]    wdata, rdata;
   logic [3:0]     wstrb;
   logic [1:0]     bresp, rresp;
   logic [N*W-1:0] regs_o;
   logic [NRO*W-1:0] status_i;
   logic [N-1:0]   wr_pulse_o;

   logic [31:0]    model_regs [N];
   logic [31:0]    status_val [NRO];
   logic [N-1:0]   exp_pulse;
   logic [N*W-1:0] exp_vec;
   int             pulse_cnt [N];
   int             errors = 0;
   int             checks = 0;

   assign status_i = {status_val[1], status_val[0]};

   gobang_axil_regs dut (
      .ACLK(clk), .ARESET(rst),
      .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
      .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
      .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
      .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
      .regs_o(regs_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // register view and update strobes against the model, every cycle out of reset
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) exp_vec[i*W +: W] = (i < N - NRO) ? model_regs[i] : '0;
         check("regs_o", 256'(regs_o), 256'(exp_vec));
         check("wr_pulse_o", 256'(wr_pulse_o), 256'(exp_pulse));
         for (int i = 0; i < N; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
      end
   end

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
      int idx;
      logic ok;
      logic [1:0] exp_resp;
      idx = int'(addr) / 4;
      ok = (addr < 8'h20) && (idx < N - NRO);
      exp_resp = ok ? 2'b00 : 2'b10;
      fork
         begin : aw_ch
            int t;
            for (int k = 0; k < aw_dly; k++) begin
               @(negedge clk); check("bvalid_before_aw", 256'(bvalid), 256'(1'b0)); step();
            end
            awaddr = addr; awvalid = 1'b1; t = 0;
            @(negedge clk);
            while (!awready && t < 40) begin t++; @(negedge clk); end
            check("aw_handshake_timeout", 256'(t < 40), 256'(1'b1));
            step(); awvalid = 1'b0;
         end
         begin : w_ch
            int t;
            for (int k = 0; k < w_dly; k++) begin
               @(negedge clk); check("bvalid_before_w", 256'(bvalid), 256'(1'b0)); step();
            end
            wdata = data; wstrb = strb; wvalid = 1'b1; t = 0;
            @(negedge clk);
            while (!wready && t < 40) begin t++; @(negedge clk); end
            check("w_handshake_timeout", 256'(t < 40), 256'(1'b1));
            step(); wvalid = 1'b0;
         end
      join
      if (ok) for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_pulse = ok ? (8'b1 << idx) : 8'b0;
      @(negedge clk);
      check("bvalid_latency", 256'(bvalid), 256'(1'b1));
      check("bresp", 256'(bresp), 256'(exp_resp));
      resp = bresp;
      for (int k = 0; k < b_dly; k++) begin
         step(); exp_pulse = '0;
         @(negedge clk);
         check("bvalid_hold", 256'(bvalid), 256'(1'b1));
         check("bresp_hold", 256'(bresp), 256'(exp_resp));
         check("awready_in_resp", 256'(awready | wready), 256'(1'b0));
      end
      step(); exp_pulse = '0; bready = 1'b1;
      @(negedge clk); check("bvalid_at_bready", 256'(bvalid), 256'(1'b1));
      step(); bready = 1'b0;
      @(negedge clk); check("bvalid_cleared", 256'(bvalid), 256'(1'b0));
      step();
   endtask

   task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      int idx, t;
      logic [31:0] exp_data;
      logic [1:0] exp_resp;
      idx = int'(addr) / 4;
      for (int k = 0; k < ar_dly; k++) step();
      araddr = addr; arvalid = 1'b1; t = 0;
      @(negedge clk);
      while (!arready && t < 40) begin t++; @(negedge clk); end
      check("ar_handshake_timeout", 256'(t < 40), 256'(1'b1));
      if (addr >= 8'h20) begin
         exp_data = '0; exp_resp = 2'b10;
      end else if (idx >= N - NRO) begin
         exp_data = status_val[idx - (N - NRO)]; exp_resp = 2'b00;
      end else begin
         exp_data = model_regs[idx]; exp_resp = 2'b00;
      end
      step(); arvalid = 1'b0;
      @(negedge clk);
      check("rvalid_latency", 256'(rvalid), 256'(1'b1));
      check("rdata", 256'(rdata), 256'(exp_data));
      check("rresp", 256'(rresp), 256'(exp_resp));
      data = rdata; resp = rresp;
      for (int k = 0; k < r_dly; k++) begin
         step();
         @(negedge clk);
         check("rvalid_hold", 256'(rvalid), 256'(1'b1));
         check("rdata_hold", 256'(rdata), 256'(exp_data));
         check("arready_in_resp", 256'(arready), 256'(1'b0));
      end
      step(); rready = 1'b1;
      @(negedge clk); check("rvalid_at_rready", 256'(rvalid), 256'(1'b1));
      step(); rready = 1'b0;
      @(negedge clk); check("rvalid_cleared", 256'(rvalid), 256'(1'b0));
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  r, rr;
      logic [31:0] d;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < N; i++) begin model_regs[i] = '0; pulse_cnt[i] = 0; end
      status_val[0] = 32'h0000_5106;
      status_val[1] = 32'hCAFE_0001;
      exp_pulse = '0;
      #1 rst = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 256'(awready), 256'(1'b0));
      check("rst_wready", 256'(wready), 256'(1'b0));
      check("rst_arready", 256'(arready), 256'(1'b0));
      check("rst_bvalid", 256'(bvalid), 256'(1'b0));
      check("rst_rvalid", 256'(rvalid), 256'(1'b0));
      check("rst_resp", 256'({bresp, rresp}), 256'(4'b0));
      check("rst_rdata", 256'(rdata), 256'(32'h0));
      check("rst_regs", 256'(regs_o), 256'(0));
      check("rst_pulse", 256'(wr_pulse_o), 256'(8'h0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check("ready_before_first_edge", 256'({awready, wready, arready}), 256'(3'b000));
      step();
      @(negedge clk); check("ready_after_first_edge", 256'({awready, wready, arready}), 256'(3'b111));
      step();

      // four words written then read back, one pulse each
      for (int i = 0; i < 4; i++) begin
         do_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, 0, r);
         check("seq_bresp", 256'(r), 256'(2'b00));
      end
      for (int i = 0; i < 4; i++) begin
         do_read(8'(i*4), 0, 0, d, r);
         check("seq_rdata_lit", 256'(d), 256'(32'(i+1)));
         check("seq_rresp", 256'(r), 256'(2'b00));
      end
      for (int i = 0; i < 4; i++) check("seq_pulse_count", 256'(pulse_cnt[i]), 256'(1));

      // byte strobes
      do_write(8'h00, 32'h1122_3344, 4'hF, 0, 0, 0, r);
      do_write(8'h00, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, r);
      do_read(8'h00, 0, 0, d, r);
      check("strobe_merge_lit", 256'(d), 256'(32'h11BB_33DD));

      // W three cycles ahead of AW, response stalled
      do_write(8'h04, 32'h5A5A_5A5A, 4'hF, 3, 0, 5, r);
      check("w_first_reg1_lit", 256'(regs_o[63:32]), 256'(32'h5A5A_5A5A));
      check("w_first_bresp", 256'(r), 256'(2'b00));
      // AW ahead of W, address byte offset ignored on read
      do_write(8'h0C, 32'h0BAD_F00D, 4'hF, 0, 2, 0, r);
      do_read(8'h07, 0, 2, d, r);
      check("byte_offset_read_lit", 256'(d), 256'(32'h5A5A_5A5A));

      // read-only, out-of-range and empty-strobe writes
      do_write(8'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r);
      check("ro_write_slverr", 256'(r), 256'(2'b10));
      do_write(8'h18, 32'h1234_5678, 4'hF, 0, 0, 0, r);
      check("ro_first_slverr", 256'(r), 256'(2'b10));
      do_write(8'h20, 32'h1234_5678, 4'hF, 0, 0, 0, r);
      check("oor_write_slverr", 256'(r), 256'(2'b10));
      do_write(8'h14, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, r);
      check("nostrobe_okay", 256'(r), 256'(2'b00));
      check("nostrobe_reg5_lit", 256'(regs_o[191:160]), 256'(32'h0));
      do_read(8'h1C, 0, 0, d, r);
      check("status7_lit", 256'(d), 256'(32'hCAFE_0001));
      check("status7_okay", 256'(r), 256'(2'b00));
      do_read(8'h20, 0, 0, d, r);
      check("oor_rdata_lit", 256'(d), 256'(32'h0));
      check("oor_rresp_lit", 256'(r), 256'(2'b10));
      check("ro_pulse_count", 256'(pulse_cnt[6] + pulse_cnt[7]), 256'(0));

      // status sampled at the address handshake, not while the response waits
      fork
         do_read(8'h18, 0, 4, d, r);
         begin step(); step(); status_val[0] = 32'h0000_600D; end
      join
      check("status_snapshot_lit", 256'(d), 256'(32'h0000_5106));
      do_read(8'h18, 0, 0, d, r);
      check("status_new_lit", 256'(d), 256'(32'h0000_600D));

      // read and write commit on the same edge to the same word
      do_write(8'h08, 32'h0, 4'hF, 0, 0, 0, r);
      fork
         do_write(8'h08, 32'h77, 4'hF, 0, 0, 0, r);
         do_read(8'h08, 0, 0, d, rr);
      join
      check("same_edge_old_lit", 256'(d), 256'(32'h0));
      do_read(8'h08, 0, 0, d, r);
      check("same_edge_new_lit", 256'(d), 256'(32'h77));

      // reset while a write response is pending
      awaddr = 8'h00; wdata = 32'h12; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk); check("rst_test_ready", 256'(awready & wready), 256'(1'b1));
      step(); awvalid = 1'b0; wvalid = 1'b0; model_regs[0] = 32'h12; exp_pulse = 8'h01;
      @(negedge clk); check("rst_test_bvalid", 256'(bvalid), 256'(1'b1));
      check("rst_test_reg0_lit", 256'(regs_o[31:0]), 256'(32'h12));
      step(); exp_pulse = '0;
      @(negedge clk); check("rst_test_pending", 256'(bvalid), 256'(1'b1));
      #1 rst = 1'b1;
      for (int i = 0; i < N; i++) model_regs[i] = '0;
      #1;
      check("async_rst_bvalid", 256'(bvalid), 256'(1'b0));
      check("async_rst_reg0", 256'(regs_o[31:0]), 256'(32'h0));
      check("async_rst_ready", 256'({awready, wready, arready}), 256'(3'b000));
      check("async_rst_pulse", 256'(wr_pulse_o), 256'(8'h0));
      step(); step(); rst = 1'b0;
      @(negedge clk); check("rerst_ready_low", 256'({awready, wready, arready}), 256'(3'b000));
      step();
      @(negedge clk);
      check("rerst_ready_high", 256'({awready, wready, arready}), 256'(3'b111));
      check("rerst_bvalid", 256'(bvalid), 256'(1'b0));
      step();
      do_read(8'h00, 0, 0, d, r);
      check("post_reset_read_lit", 256'(d), 256'(32'h0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gobang_axil_regs.md
GOBANG_AXIL_REGS -- requirements
Module: gobang_axil_regs

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, meaning AXI data width in bits (32 or 64 only).
REQ-002 SHALL have parameter C_NUM_REGS, default 8, meaning total word registers (power of two, 4..64).
REQ-003 SHALL have parameter C_NUM_RO, default 2, meaning count of top-indexed read-only status registers (0..C_NUM_REGS-1).
REQ-004 SHALL have parameter C_ADDR_WIDTH, default 8, meaning AWADDR/ARADDR width; must be >= log2(C_NUM_REGS)+log2(C_DATA_WIDTH/8).
REQ-005 SHALL have ports ACLK in 1 (clock) and ARESET in 1 (reset); one clock; reset is asynchronous and active-high.
REQ-006 SHALL have AXI4-Lite slave ports AWADDR/ARADDR in C_ADDR_WIDTH, AWPROT/ARPROT in 3 (ignored), AWVALID/WVALID/BREADY/ARVALID/RREADY in 1, WDATA in C_DATA_WIDTH, WSTRB in C_DATA_WIDTH/8.
REQ-007 SHALL have outputs AWREADY/WREADY/BVALID/ARREADY/RVALID out 1, BRESP/RRESP out 2, RDATA out C_DATA_WIDTH.
REQ-008 SHALL have regs_o out C_NUM_REGS*C_DATA_WIDTH (register i at bits [i*W +: W]), status_i in C_NUM_RO*C_DATA_WIDTH, wr_pulse_o out C_NUM_REGS.

Function
REQ-009 SHALL decode index = addr[log2(W/8) +: log2(C_NUM_REGS)]; address bits above the index field nonzero = out of range; low byte-offset bits ignored.
REQ-010 SHALL implement write FSM W_ACCEPT -> W_RESP; in W_ACCEPT AWREADY=1 until AW captured, WREADY=1 until W captured, in any order or same cycle.
REQ-011 SHALL, on the edge after both AW and W are captured, commit the write and enter W_RESP with BVALID=1 in the same cycle the new register value appears on regs_o.
REQ-012 SHALL hold BVALID, BRESP stable in W_RESP until BREADY=1, then return to W_ACCEPT next cycle; AWREADY=WREADY=0 throughout W_RESP.
REQ-013 SHALL apply WSTRB per byte: byte k of target updated only if WSTRB[k]=1; WSTRB=0 is a legal no-op with OKAY.
REQ-014 SHALL, for out-of-range or read-only index (i >= C_NUM_REGS-C_NUM_RO), suppress the update, give BRESP=2'b10 (SLVERR), and not pulse wr_pulse_o.
REQ-015 SHALL pulse wr_pulse_o[i] high for exactly one cycle, coincident with first BVALID cycle, on each successful write to register i.
REQ-016 SHALL implement read FSM R_IDLE -> R_RESP; ARREADY=1 only in R_IDLE; on AR handshake latch RDATA and RRESP, enter R_RESP with RVALID=1 next cycle.
REQ-017 SHALL hold RVALID/RDATA/RRESP until RREADY=1, then return to R_IDLE; read latency from ARVALID handshake to RVALID = 1 cycle.
REQ-018 SHALL return RW register contents, or status_i slice (sampled at AR handshake edge) for read-only indices; out-of-range returns 0 with RRESP=2'b10.
REQ-019 SHALL run read and write FSMs independently; a read handshaking on the same edge as a write commit to the same index returns the pre-write value.
REQ-020 SHALL drive regs_o slices for read-only indices to the latched status value is NOT required; those slices SHALL read as 0 on regs_o.

Reset
REQ-021 SHALL, while ARESET=1, force both FSMs to idle, all RW registers to 0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse_o=0, AWREADY=WREADY=ARREADY=0.
REQ-022 SHALL assert AWREADY, WREADY, ARREADY on the first ACLK edge after ARESET deasserts; reset mid-transaction discards it with no response.

Verification
REQ-023 Write 0x00000001..0x00000004 to 0x00,0x04,0x08,0x0C then read back -> RDATA matches each, all RESP=OKAY, wr_pulse_o[0..3] each pulse once.
REQ-024 Reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 to 0x00 -> read 0x11BB33DD.
REQ-025 W beat 3 cycles before AW to 0x04 with data 0x5A5A5A5A -> BVALID one cycle after AW handshake, reg1=0x5A5A5A5A; BREADY held low 5 cycles -> BVALID, BRESP stable.
REQ-026 Defaults: write 0xDEADBEEF to 0x1C (reg7, RO) -> BRESP=SLVERR, no pulse; status_i reg7=0xCAFE0001, read 0x1C -> 0xCAFE0001 OKAY; read 0x20 -> 0, SLVERR.
REQ-027 Reg2=0x0, same-edge AR and write-commit to 0x08 with 0x77 -> RDATA=0x0, later read 0x77.
REQ-028 Assert ARESET with BVALID pending and reg0=0x12 -> BVALID=0 immediately, reg0=0, first read after release returns 0.
